matrix_scan_driver: RTL

- Sequential successor to the combinational glyph decoder.
- Accepts a flat COLS x ROWS active-low pixel map from a map decoder and stores it in a display buffer.
- Time-multiplexes the buffer onto a physical LED matrix, one column at a time.
- Adds what the decoder lacks: column scanning, an optional column-by-column scroll-in transition on load, and frame-based blinking, all parametrised in matrix size and timing.

---
 rtl/matrix_scan_driver.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/matrix_scan_driver.sv
// Column-multiplexed LED matrix driver with a display buffer, optional
// column-by-column scroll-in on load, and frame-based blinking.
module matrix_scan_driver #(
  parameter int ROWS          = 7,
  parameter int COLS          = 5,
  parameter int SCAN_DIV      = 1000,
  parameter int SCROLL_FRAMES = 8,
  parameter int BLINK_FRAMES  = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] map_in,
  input  logic                 load,
  input  logic                 mode_scroll,
  input  logic                 blink,
  input  logic                 enable,
  output logic                 busy,
  output logic [COLS-1:0]      col_sel,
  output logic [ROWS-1:0]      row_out,
  output logic                 frame_tick
);

  // state   | meaning
  // S_IDLE   | buffer static; loads accepted
  // S_SCROLL | shifting pending map in, one column per SCROLL_FRAMES frames

  localparam int PW = (SCAN_DIV > 1)      ? $clog2(SCAN_DIV)      : 1;
  localparam int CW = (COLS > 1)          ? $clog2(COLS)          : 1;
  localparam int SW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam int BW = (BLINK_FRAMES > 1)  ? $clog2(BLINK_FRAMES)  : 1;

  localparam logic [PW-1:0] P_TC   = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
  localparam logic [SW-1:0] S_TC   = SW'(SCROLL_FRAMES - 1);
  localparam logic [BW-1:0] B_TC   = BW'(BLINK_FRAMES - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SCROLL = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [PW-1:0]          r_presc;
  logic [CW-1:0]          r_col;
  logic                   r_frame_tick;
  logic [BW-1:0]          r_bcnt;
  logic                   r_phase;
  logic [SW-1:0]          r_scnt;
  logic [CW-1:0]          r_k;
  logic [ROWS*COLS-1:0]   r_disp;
  logic [ROWS*COLS-1:0]   r_pending;
  logic [COLS-1:0]        r_col_sel;
  logic [ROWS-1:0]        r_row_out;

  logic                   w_presc_tc;
  logic                   w_load_imm;
  logic                   w_load_scroll;
  logic                   w_scroll_tick;
  logic                   w_shift;
  logic [ROWS*COLS-1:0]   w_disp_shifted;
  logic [COLS-1:0]        w_col_n;
  logic [ROWS-1:0]        w_row_sel;

  assign w_presc_tc = (r_presc == P_TC);

  // Scan timing: prescaler, column index and the frame pulse on index wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc      <= '0;
      r_col        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      if (w_presc_tc) begin
        r_presc <= '0;
        if (r_col == C_LAST) begin
          r_col        <= '0;
          r_frame_tick <= 1'b1;
        end else begin
          r_col <= r_col + CW'(1);
        end
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Blink counter and phase are held clear while blink is low
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (!blink) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (r_frame_tick) begin
      if (r_bcnt == B_TC) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_scroll_tick = (r_state == S_SCROLL) && r_frame_tick;

  always_comb begin
    w_state_nxt   = r_state;
    w_load_imm    = 1'b0;
    w_load_scroll = 1'b0;
    w_shift       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          if (mode_scroll) begin
            w_load_scroll = 1'b1;
            w_state_nxt   = S_SCROLL;
          end else begin
            w_load_imm = 1'b1;
          end
        end
      end
      S_SCROLL: begin
        if (w_scroll_tick && (r_scnt == S_TC)) begin
          w_shift = 1'b1;
          if (r_k == C_LAST) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Buffer moves one column left; pending column k enters on the right
  always_comb begin
    w_disp_shifted = r_disp >> ROWS;
    for (int c = 0; c < COLS; c++) begin
      if (r_k == CW'(c)) begin
        w_disp_shifted[(COLS-1)*ROWS +: ROWS] = r_pending[c*ROWS +: ROWS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp    <= '1;
      r_pending <= '1;
      r_k       <= '0;
      r_scnt    <= '0;
    end else begin
      if (w_load_imm) begin
        r_disp <= map_in;
      end
      if (w_load_scroll) begin
        r_pending <= map_in;
        r_k       <= '0;
        r_scnt    <= '0;
      end
      if (w_scroll_tick) begin
        r_scnt <= (r_scnt == S_TC) ? '0 : r_scnt + SW'(1);
      end
      if (w_shift) begin
        r_disp <= w_disp_shifted;
        r_k    <= r_k + CW'(1);
      end
    end
  end

  always_comb begin
    w_col_n   = '1;
    w_row_sel = '1;
    for (int c = 0; c < COLS; c++) begin
      if (r_col == CW'(c)) begin
        w_col_n[c] = 1'b0;
        w_row_sel  = r_disp[c*ROWS +: ROWS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_sel <= '1;
      r_row_out <= '1;
    end else if (enable) begin
      r_col_sel <= w_col_n;
      r_row_out <= (blink && r_phase) ? '1 : w_row_sel;
    end else begin
      r_col_sel <= '1;
      r_row_out <= '1;
    end
  end

  assign busy       = (r_state == S_SCROLL);
  assign col_sel    = r_col_sel;
  assign row_out    = r_row_out;
  assign frame_tick = r_frame_tick;

endmodule
